// File: rtl/spill_register.sv
// Spill register: a two-entry elastic buffer that cuts every combinational
// path between the upstream and downstream valid/ready handshakes.
// With Bypass set, it becomes plain wires with no storage.
module spill_register #(
    parameter type  T      = logic,
    parameter logic Bypass = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    if (Bypass) begin : g_bypass

        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;

    end else begin : g_spill

        logic a_full;
        logic b_full;
        T     a_data;
        T     b_data;
        logic a_fill;
        logic a_drain;
        logic b_fill;
        logic b_drain;

        // Slot control. A always empties while B is free, either straight
        // downstream or into B when downstream stalls. B therefore always
        // holds the older word whenever both slots are occupied.
        always_comb begin
            a_fill  = valid_i & ready_o;
            a_drain = a_full & ~b_full;
            b_fill  = a_drain & ~ready_i;
            b_drain = b_full & ready_i;
        end

        // Slot state: reset clears flags and payloads; otherwise update on fill/drain.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                a_full <= 1'b0;
                b_full <= 1'b0;
                a_data <= '0;
                b_data <= '0;
            end else begin
                if (a_fill) begin
                    a_data <= data_i;
                end
                if (a_fill | a_drain) begin
                    a_full <= a_fill;
                end
                if (b_fill) begin
                    b_data <= a_data;
                end
                if (b_fill | b_drain) begin
                    b_full <= b_fill;
                end
            end
        end

        // Outputs are driven from registered state only.
        always_comb begin
            ready_o = ~a_full | ~b_full;
            valid_o = a_full | b_full;
            data_o  = b_full ? b_data : a_data;
        end

    end

endmodule

// File: tb/tb_spill_register.sv
// Self-checking bench for spill_register: a directed vector table,
// streaming and randomised scoreboard sequences, plus a bypass instance.
module tb_spill_register;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o;

    logic       bp_valid_i;
    logic       bp_ready_o;
    logic [7:0] bp_data_i;
    logic       bp_valid_o;
    logic       bp_ready_i;
    logic [7:0] bp_data_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    spill_register #(
        .T      (logic [7:0]),
        .Bypass (1'b0)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    spill_register #(
        .T      (logic [7:0]),
        .Bypass (1'b1)
    ) dut_bp (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (bp_valid_i),
        .ready_o (bp_ready_o),
        .data_i  (bp_data_i),
        .valid_o (bp_valid_o),
        .ready_i (bp_ready_i),
        .data_o  (bp_data_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       ready;
        logic       exp_valid;
        logic       exp_ready;
        logic [7:0] exp_data;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    logic [7:0] sb[$];
    logic [7:0] exp_word;
    logic       hold;
    logic [7:0] hold_data;
    int unsigned pushed;
    int unsigned popped;
    int unsigned cycles;

    initial begin
        // Inputs applied before an edge, expected outputs observed after it.
        //          rst   valid data   ready  vo    ro    do
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00}; // reset
        vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5}; // accept A5
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5}; // A5 leaves
        vecs[3]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11}; // push 11, stalled
        vecs[4]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11}; // push 22 -> full
        vecs[5]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 8'h11}; // full, 33 refused
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22}; // pop 11
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22}; // pop 22
        vecs[8]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h44}; // push 44
        vecs[9]  = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55}; // pop 44 + push 55
        vecs[10] = '{1'b0, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 8'h55}; // push 66 -> full
        vecs[11] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h66}; // pop 55, 77 refused
        vecs[12] = '{1'b0, 1'b1, 8'h88, 1'b0, 1'b1, 1'b0, 8'h66}; // push 88 -> full
        vecs[13] = '{1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'h00}; // reset while full
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00}; // idle after reset

        rst        = 1'b1;
        valid_i    = 1'b0;
        data_i     = 8'h00;
        ready_i    = 1'b0;
        bp_valid_i = 1'b0;
        bp_data_i  = 8'h00;
        bp_ready_i = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            rst     = vecs[i].rst;
            valid_i = vecs[i].valid;
            data_i  = vecs[i].data;
            ready_i = vecs[i].ready;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid_o", i), {31'b0, valid_o}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d ready_o", i), {31'b0, ready_o}, {31'b0, vecs[i].exp_ready});
            check($sformatf("vec%0d data_o", i), {24'b0, data_o}, {24'b0, vecs[i].exp_data});
        end

        // Back-to-back stream: one word per cycle, one-cycle offset.
        for (int i = 1; i <= 16; i++) begin
            valid_i = 1'b1;
            data_i  = 8'(i);
            ready_i = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("stream%0d valid_o", i), {31'b0, valid_o}, 32'd1);
            check($sformatf("stream%0d data_o", i), {24'b0, data_o}, i);
            check($sformatf("stream%0d ready_o", i), {31'b0, ready_o}, 32'd1);
        end
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        check("stream_end valid_o", {31'b0, valid_o}, 32'd0);

        // Random handshakes against a FIFO scoreboard.
        pushed = 0;
        popped = 0;
        cycles = 0;
        hold   = 1'b0;
        hold_data = 8'h00;
        while (popped < 1000 && cycles < 20000) begin
            valid_i = (pushed < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            data_i  = 8'($urandom);
            ready_i = 1'($urandom_range(0, 1));
            if (hold) begin
                check("rand hold valid_o", {31'b0, valid_o}, 32'd1);
                check("rand hold data_o", {24'b0, data_o}, {24'b0, hold_data});
            end
            check("rand occupancy ready_o", {31'b0, ready_o}, {31'b0, sb.size() < 2});
            check("rand occupancy valid_o", {31'b0, valid_o}, {31'b0, sb.size() != 0});
            if (valid_o && ready_i && sb.size() != 0) begin
                exp_word = sb.pop_front();
                check("rand order data_o", {24'b0, data_o}, {24'b0, exp_word});
                popped++;
            end
            if (valid_i && ready_o) begin
                sb.push_back(data_i);
                pushed++;
            end
            hold      = valid_o & ~ready_i;
            hold_data = data_o;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("rand words delivered", popped, 32'd1000);
        valid_i = 1'b0;
        ready_i = 1'b0;

        // Bypass instance is purely combinational.
        bp_valid_i = 1'b1;
        bp_data_i  = 8'h3C;
        bp_ready_i = 1'b0;
        #1;
        check("bypass valid_o", {31'b0, bp_valid_o}, 32'd1);
        check("bypass data_o", {24'b0, bp_data_o}, 32'h3C);
        check("bypass ready_o", {31'b0, bp_ready_o}, 32'd0);
        bp_valid_i = 1'b0;
        bp_data_i  = 8'hC3;
        bp_ready_i = 1'b1;
        #1;
        check("bypass2 valid_o", {31'b0, bp_valid_o}, 32'd0);
        check("bypass2 data_o", {24'b0, bp_data_o}, 32'hC3);
        check("bypass2 ready_o", {31'b0, bp_ready_o}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spill_register.md
SPILL_REGISTER -- requirements
Module: spill_register

Interface
REQ-001 Parameter T, default logic (1 bit): payload type; payload width W = $bits(T), W >= 1.
REQ-002 Parameter Bypass, default 1'b0: 1 = combinational pass-through, 0 = registered two-entry cut.
REQ-003 Port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  reset; synchronous, active-high.
REQ-005 Port valid_i  input  1  upstream data valid.
REQ-006 Port ready_o  output  1  upstream ready; a transfer occurs when valid_i=1 and ready_o=1.
REQ-007 Port data_i  input  W (type T)  upstream payload.
REQ-008 Port valid_o  output  1  downstream data valid.
REQ-009 Port ready_i  input  1  downstream ready; a transfer occurs when valid_o=1 and ready_i=1.
REQ-010 Port data_o  output  W (type T)  downstream payload.

Function
REQ-011 Bypass=1: valid_o=valid_i, ready_o=ready_i, data_o=data_i, purely combinational; no state is used.
REQ-012 Bypass=0: storage is two slots, A (a_full, a_data) and B (b_full, b_data); capacity 2 entries.
REQ-013 Outputs are functions of registered state only: ready_o = !a_full | !b_full; valid_o = a_full | b_full; data_o = b_full ? b_data : a_data.
REQ-014 No combinational path from valid_i/data_i to any output, and none from ready_i to ready_o.
REQ-015 a_fill = valid_i & ready_o; on a_fill, a_data <= data_i.
REQ-016 a_drain = a_full & !b_full (A leaves every cycle B is empty, either downstream or into B).
REQ-017 If a_fill | a_drain: a_full <= a_fill; otherwise a_full holds.
REQ-018 b_fill = a_drain & !ready_i; on b_fill, b_data <= a_data.
REQ-019 b_drain = b_full & ready_i; if b_fill | b_drain: b_full <= b_fill; otherwise b_full holds.
REQ-020 Latency: a word accepted in cycle n appears at valid_o/data_o in cycle n+1 at the earliest.
REQ-021 Throughput: with ready_i held at 1, one word per cycle is sustained indefinitely.
REQ-022 Ordering: strict FIFO; no word is lost, duplicated or reordered under any valid_i/ready_i pattern.
REQ-023 Full (a_full=b_full=1): ready_o=0, data_o=b_data; after a downstream transfer, ready_o=1 in the next cycle.
REQ-024 Simultaneous accept and output in the same cycle is allowed in every state where ready_o=1.
REQ-025 data_o is held stable while valid_o=1 and ready_i=0.

Reset
REQ-026 While rst_i=1 at a clock edge: a_full<=0, b_full<=0, a_data<=0, b_data<=0; any stored data is discarded, including mid-transfer.
REQ-027 After reset: valid_o=0, ready_o=1, data_o=0.
REQ-028 Bypass=1 has no reset behaviour; outputs follow inputs.

Verification
REQ-029 Reset, then valid_i=1, data_i=0xA5, ready_i=1 for one cycle -> next cycle valid_o=1, data_o=0xA5; following cycle valid_o=0.
REQ-030 ready_i=0, push 0x11 then 0x22 -> ready_o=0 after second accept, data_o=0x11; raise ready_i -> outputs 0x11, then 0x22, ready_o=1 again one cycle after the first pop.
REQ-031 Stream 0x01..0x10 with valid_i=1 and ready_i=1 each cycle -> data_o emits 0x01..0x10 in consecutive cycles, one-cycle offset, no bubbles.
REQ-032 Random valid_i/ready_i (50%) for 1000 words -> scoreboard matches exact in-order sequence; data_o stable while valid_o=1 and ready_i=0.
REQ-033 Fill both slots, assert rst_i for one cycle -> valid_o=0, ready_o=1, data_o=0 the next cycle.
REQ-034 Bypass=1, drive valid_i=1, data_i=0x3C, ready_i=0 -> same cycle valid_o=1, data_o=0x3C, ready_o=0.
